// File: rtl/vend_fsm_param_pkg.sv
// Shared types for the parametrised vending controller:
// one-hot state encoding and the credit width helper.
package vend_fsm_param_pkg;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_CREDIT = 5'b00010,
    ST_VEND   = 5'b00100,
    ST_CHANGE = 5'b01000,
    ST_REFUND = 5'b10000
  } state_e;

  function automatic int cw_f(
    input int price,
    input int c0,
    input int c1
  );
    int mx;
    mx = (c0 > c1) ? c0 : c1;
    return $clog2(price + mx) + 1;
  endfunction

endpackage

// File: rtl/vend_fsm_param_payout_cnt.sv
// Loadable down-counter for change/refund payout:
// one pulse per remaining count, done on the last one.
module vend_fsm_param_payout_cnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          pulse,
  output logic          done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign pulse = (cnt != '0);
  assign done  = (cnt == CW'(1));

endmodule

// File: rtl/vend_fsm_param.sv
// Coin vending controller: credit accumulation, vend,
// change payout, cancel refund and inactivity timeout.
module vend_fsm_param
  import vend_fsm_param_pkg::*;
#(
  parameter int PRICE     = 5,
  parameter int COIN0_VAL = 1,
  parameter int COIN1_VAL = 2,
  parameter int TIMEOUT   = 100,
  localparam int CW = cw_f(PRICE, COIN0_VAL, COIN1_VAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pi_coin_vld,
  input  logic          pi_coin_sel,
  output logic          po_coin_rdy,
  input  logic          pi_cancel,
  output logic          po_cola,
  output logic          po_change,
  output logic          po_busy,
  output logic [CW-1:0] po_credit
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e        state;
  logic [CW-1:0] credit;
  logic [TW-1:0] timer;
  logic [CW-1:0] coin_val;
  logic [CW-1:0] credit_nxt;
  logic [CW-1:0] credit_sum;
  logic [CW-1:0] pay_val;
  logic          coin_acc;
  logic          timeout_hit;
  logic          to_refund;
  logic          pay_load;
  logic          pay_done;

  assign po_coin_rdy = (state == ST_IDLE) || (state == ST_CREDIT);
  assign po_credit   = po_coin_rdy ? credit : '0;
  assign coin_acc    = pi_coin_vld && po_coin_rdy;
  assign timeout_hit = (TIMEOUT != 0) && (timer == T_LAST);

  always_comb begin
    coin_val   = pi_coin_sel ? CW'(COIN1_VAL) : CW'(COIN0_VAL);
    credit_nxt = credit + coin_val;
    credit_sum = coin_acc ? credit_nxt : credit;
    to_refund  = (state == ST_CREDIT) &&
                 (pi_cancel || (!coin_acc && timeout_hit));
    pay_load   = to_refund || (state == ST_VEND);
    pay_val    = (state == ST_VEND) ?
                 credit - CW'(PRICE) : credit_sum;
  end

  vend_fsm_param_payout_cnt #(
    .CW(CW)
  ) u_payout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pay_load),
    .load_val (pay_val),
    .pulse    (po_change),
    .done     (pay_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      credit  <= '0;
      timer   <= '0;
      po_cola <= 1'b0;
      po_busy <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_CREDIT: begin
          if (to_refund) begin
            state   <= ST_REFUND;
            credit  <= '0;
            po_busy <= 1'b1;
          end else if (coin_acc) begin
            credit <= credit_nxt;
            timer  <= '0;
            if (credit_nxt >= CW'(PRICE)) begin
              state   <= ST_VEND;
              po_cola <= 1'b1;
              po_busy <= 1'b1;
            end else begin
              state <= ST_CREDIT;
            end
          end else if (state == ST_CREDIT) begin
            timer <= timer + TW'(1);
          end
        end
        ST_VEND: begin
          po_cola <= 1'b0;
          credit  <= '0;
          if (credit > CW'(PRICE)) begin
            state <= ST_CHANGE;
          end else begin
            state   <= ST_IDLE;
            po_busy <= 1'b0;
          end
        end
        ST_CHANGE, ST_REFUND: begin
          if (pay_done) begin
            state   <= ST_IDLE;
            po_busy <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          po_cola <= 1'b0;
          po_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_fsm_param.sv
// Randomised and directed bench for vend_fsm_param
// against a credit/payout reference model.
module tb_vend_fsm_param;

  localparam int PRICE = 5;
  localparam int V0    = 1;
  localparam int V1    = 2;
  localparam int TO    = 10;
  localparam int CW    = $clog2(PRICE + 2) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pi_coin_vld = 1'b0;
  logic          pi_coin_sel = 1'b0;
  logic          pi_cancel = 1'b0;
  logic          po_coin_rdy;
  logic          po_cola;
  logic          po_change;
  logic          po_busy;
  logic [CW-1:0] po_credit;

  int n_checks = 0;
  int n_pass   = 0;
  int n_cola   = 0;
  int n_chg    = 0;

  vend_fsm_param #(
    .PRICE     (PRICE),
    .COIN0_VAL (V0),
    .COIN1_VAL (V1),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pi_coin_vld (pi_coin_vld),
    .pi_coin_sel (pi_coin_sel),
    .po_coin_rdy (po_coin_rdy),
    .pi_cancel   (pi_cancel),
    .po_cola     (po_cola),
    .po_change   (po_change),
    .po_busy     (po_busy),
    .po_credit   (po_credit)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (po_cola)   n_cola++;
    if (po_change) n_chg++;
  end

  task automatic coin(input logic sel, input logic cancel);
    int w;
    w = 0;
    while (!po_coin_rdy && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!po_coin_rdy) begin
      n_checks++;
      $display("FAIL coin_rdy_wait: rdy=%0b after %0d cycles want 1",
               po_coin_rdy, w);
    end
    pi_coin_vld = 1'b1;
    pi_coin_sel = sel;
    pi_cancel   = cancel;
    @(posedge clk);
    @(negedge clk);
    pi_coin_vld = 1'b0;
    pi_cancel   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({po_cola, po_change, po_busy} !== 3'b000) begin
      $display("FAIL reset_outs: got %b want 000",
               {po_cola, po_change, po_busy});
    end else n_pass++;
    n_checks++;
    if (po_credit !== '0 || po_coin_rdy !== 1'b1) begin
      $display("FAIL reset_credit_rdy: credit=%0d rdy=%0b want 0/1",
               po_credit, po_coin_rdy);
    end else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_exact();
    coin(1'b0, 1'b0);
    n_checks++;
    if (po_credit !== CW'(1))
      $display("FAIL exact_credit1: got %0d want 1", po_credit);
    else n_pass++;
    coin(1'b1, 1'b0);
    n_checks++;
    if (po_credit !== CW'(3))
      $display("FAIL exact_credit3: got %0d want 3", po_credit);
    else n_pass++;
    coin(1'b1, 1'b0);
    n_checks++;
    if ({po_cola, po_busy, po_coin_rdy} !== 3'b110 || po_credit !== '0)
      $display("FAIL exact_vend: cola/busy/rdy=%b credit=%0d want 110/0",
               {po_cola, po_busy, po_coin_rdy}, po_credit);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({po_cola, po_change, po_busy, po_coin_rdy} !== 4'b0001)
      $display("FAIL exact_idle: cola/chg/busy/rdy=%b want 0001",
               {po_cola, po_change, po_busy, po_coin_rdy});
    else n_pass++;
  endtask

  task automatic test_change();
    repeat (3) coin(1'b1, 1'b0);
    n_checks++;
    if (po_cola !== 1'b1)
      $display("FAIL change_cola: got %0b want 1", po_cola);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({po_cola, po_change, po_busy} !== 3'b011)
      $display("FAIL change_pulse: cola/chg/busy=%b want 011",
               {po_cola, po_change, po_busy});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({po_change, po_busy, po_coin_rdy} !== 3'b001)
      $display("FAIL change_end: chg/busy/rdy=%b want 001",
               {po_change, po_busy, po_coin_rdy});
    else n_pass++;
  endtask

  task automatic test_cancel();
    int c0;
    c0 = n_cola;
    coin(1'b1, 1'b0);
    coin(1'b0, 1'b0);
    n_checks++;
    if (po_credit !== CW'(3))
      $display("FAIL cancel_credit: got %0d want 3", po_credit);
    else n_pass++;
    pi_cancel = 1'b1;
    @(negedge clk);
    pi_cancel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (po_change !== 1'b1 || po_credit !== '0)
        $display("FAIL cancel_pulse%0d: chg=%0b credit=%0d want 1/0",
                 i, po_change, po_credit);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if (po_change !== 1'b0 || po_coin_rdy !== 1'b1 || n_cola != c0)
      $display("FAIL cancel_end: chg=%0b rdy=%0b colas=%0d want 0/1/0",
               po_change, po_coin_rdy, n_cola - c0);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int k;
    coin(1'b0, 1'b0);
    k = 0;
    while (!po_change && k < 30) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k != TO)
      $display("FAIL timeout_delay: got %0d cycles want %0d", k, TO);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (po_change !== 1'b0 || po_coin_rdy !== 1'b1)
      $display("FAIL timeout_end: chg=%0b rdy=%0b want 0/1",
               po_change, po_coin_rdy);
    else n_pass++;
  endtask

  task automatic test_coin_in_change();
    int h0;
    h0 = n_chg;
    repeat (3) coin(1'b1, 1'b0);
    pi_coin_vld = 1'b1;
    pi_coin_sel = 1'b1;
    #1;
    n_checks++;
    if (po_coin_rdy !== 1'b0)
      $display("FAIL busy_rdy_vend: got %0b want 0", po_coin_rdy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (po_coin_rdy !== 1'b0 || po_change !== 1'b1 || po_credit !== '0)
      $display("FAIL busy_rdy_change: rdy=%0b chg=%0b credit=%0d want 0/1/0",
               po_coin_rdy, po_change, po_credit);
    else n_pass++;
    pi_coin_vld = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_chg - h0 != 1 || po_credit !== '0)
      $display("FAIL busy_no_extra: pulses=%0d credit=%0d want 1/0",
               n_chg - h0, po_credit);
    else n_pass++;
  endtask

  task automatic test_reset_mid_refund();
    int h0;
    coin(1'b1, 1'b0);
    coin(1'b1, 1'b0);
    pi_cancel = 1'b1;
    @(negedge clk);
    pi_cancel = 1'b0;
    n_checks++;
    if (po_change !== 1'b1)
      $display("FAIL rst_refund_start: chg=%0b want 1", po_change);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({po_cola, po_change, po_busy} !== 3'b000 ||
        po_credit !== '0 || po_coin_rdy !== 1'b1)
      $display("FAIL rst_refund_outs: cola/chg/busy=%b credit=%0d rdy=%0b",
               {po_cola, po_change, po_busy}, po_credit, po_coin_rdy);
    else n_pass++;
    h0 = n_chg;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    n_checks++;
    if (n_chg != h0 || po_busy !== 1'b0)
      $display("FAIL rst_refund_quiet: pulses=%0d busy=%0b want 0/0",
               n_chg - h0, po_busy);
    else n_pass++;
  endtask

  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      int   kind, sum, v, c0, h0, e_cola, e_chg;
      logic sel;
      bit   done;
      kind = $urandom_range(0, 2);
      sum = 0; done = 0; e_cola = 0; e_chg = 0;
      c0 = n_cola; h0 = n_chg;
      if ($urandom_range(0, 3) == 0) begin
        pi_cancel = 1'b1;
        @(negedge clk);
        pi_cancel = 1'b0;
      end
      while (!done) begin
        sel = 1'($urandom_range(0, 1));
        v = sel ? V1 : V0;
        if (kind == 0) begin
          coin(sel, 1'b0);
          sum += v;
          if (sum >= PRICE) begin
            e_cola = 1; e_chg = sum - PRICE; done = 1;
          end
        end else if (kind == 1 && sum + v >= PRICE) begin
          coin(sel, 1'b1);
          sum += v; e_chg = sum; done = 1;
        end else if (kind == 1 && sum > 0 &&
                     $urandom_range(0, 2) == 0) begin
          pi_cancel = 1'b1;
          @(negedge clk);
          pi_cancel = 1'b0;
          e_chg = sum; done = 1;
        end else if (kind == 2 && (sum + v >= PRICE ||
                     (sum > 0 && $urandom_range(0, 1) == 1))) begin
          e_chg = sum; done = 1;
        end else begin
          coin(sel, 1'b0);
          sum += v;
        end
        if (!done) begin
          n_checks++;
          if (po_credit !== CW'(sum))
            $display("FAIL rnd%0d_credit: got %0d want %0d",
                     t, po_credit, sum);
          else n_pass++;
          repeat ($urandom_range(0, 4)) @(negedge clk);
        end
      end
      repeat (20) @(negedge clk);
      n_checks++;
      if (n_cola - c0 != e_cola || n_chg - h0 != e_chg)
        $display("FAIL rnd%0d_payout k%0d: cola=%0d chg=%0d want %0d/%0d",
                 t, kind, n_cola - c0, n_chg - h0, e_cola, e_chg);
      else n_pass++;
      n_checks++;
      if (po_credit !== '0 || po_coin_rdy !== 1'b1 || po_busy !== 1'b0)
        $display("FAIL rnd%0d_settle: credit=%0d rdy=%0b busy=%0b",
                 t, po_credit, po_coin_rdy, po_busy);
      else n_pass++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_exact();
    test_change();
    test_cancel();
    test_timeout();
    test_coin_in_change();
    test_reset_mid_refund();
    test_random(40);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
